// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Types shared across the 5-stage MIPS core.
//   regbits_t : 5-bit architectural register index ($0..$31)
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

endpackage

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller for the 5-stage MIPS core. It shadows the
// destination and memory-access bits of the instructions in EX, MEM and WB,
// supplies the producer side of the forwarding network, and generates every
// pipeline-register enable and flush (load-use stall, memory waits, redirect).
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   ihit, dhit               instruction fetch / data access completed
//   dec_rs, dec_rt           source registers of the ID instruction
//   dec_uses_rt              ID instruction reads rt as a source
//   dec_rd                   resolved destination of the ID instruction
//   dec_regwr/memrd/memwr    control bits of the ID instruction
//   ex_redirect              EX instruction is a taken branch or jump
//   pc_en .. memwb_en        pipeline register load enables
//   ifid/idex/exmem_flush    synchronous clear to bubble (overrides enable)
//   rd_mem, wr_mem, wm_mem   MEM-stage destination / reg write / store
//   mem_rt                   rt field of the MEM instruction
//   rd_wb, wr_wb             WB-stage destination / reg write
//   hz_state                 registered hazard state (RUN/LDSTALL/MEMWAIT/REDIRECT)
//   stall_cnt                saturating count of cycles with pc_en = 0
// -----------------------------------------------------------------------------
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  regbits_t    dec_rs,
    input  regbits_t    dec_rt,
    input  logic        dec_uses_rt,
    input  regbits_t    dec_rd,
    input  logic        dec_regwr,
    input  logic        dec_memrd,
    input  logic        dec_memwr,
    input  logic        ex_redirect,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output regbits_t    rd_mem,
    output regbits_t    rd_wb,
    output logic        wr_mem,
    output logic        wr_wb,
    output logic        wm_mem,
    output regbits_t    mem_rt,
    output logic [1:0]  hz_state,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LDSTALL  = 2'd1,
        MEMWAIT  = 2'd2,
        REDIRECT = 2'd3
    } hz_state_t;

    // Shadow copy of the fields the hazard logic needs from one instruction.
    typedef struct packed {
        regbits_t rd;
        regbits_t rt;
        logic     wr;
        logic     memrd;
        logic     memwr;
    } stage_t;

    stage_t    dec_stage;
    stage_t    ex_q;
    stage_t    mem_q;
    regbits_t  wb_rd;
    logic      wb_wr;
    hz_state_t state_q;
    hz_state_t state_d;
    logic      mem_busy;
    logic      load_use;

    assign dec_stage = '{rd: dec_rd, rt: dec_rt, wr: dec_regwr,
                         memrd: dec_memrd, memwr: dec_memwr};

    // A MEM-stage access that has not completed freezes the whole pipe.
    assign mem_busy = (mem_q.memrd | mem_q.memwr) & ~dhit;

    // A load whose result is needed by the very next instruction; $0 is
    // never a real producer.
    assign load_use = ex_q.memrd & ex_q.wr & (ex_q.rd != '0) &
                      ((ex_q.rd == dec_rs) | (dec_uses_rt & (ex_q.rd == dec_rt)));

    // Control decision, highest priority first.
    always_comb begin
        // NOTE: every output gets a default before the priority chain so no
        // path leaves a signal unassigned and no latch is inferred.
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = RUN;

        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (mem_busy) begin
            // Everything holds, including a redirect waiting in EX.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = MEMWAIT;
        end else if (ex_redirect) begin
            // Squash the two younger instructions; the PC loads the target
            // even if the current fetch has not returned.
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = REDIRECT;
        end else if (load_use) begin
            // Hold IF/ID, inject one bubble into EX, let the load advance.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = LDSTALL;
        end else if (!ihit) begin
            // Fetch wait: feed a bubble into ID while older work drains.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its sources.
        if (RST) begin
            // NOTE: all shadow fields are reset explicitly; the set is small
            // and a reset mid-stall must discard every in-flight copy.
            ex_q      <= '0;
            mem_q     <= '0;
            wb_rd     <= '0;
            wb_wr     <= 1'b0;
            state_q   <= RUN;
            stall_cnt <= '0;
        end else begin
            if (idex_flush)
                ex_q <= '0;
            else if (idex_en)
                ex_q <= dec_stage;

            if (exmem_flush)
                mem_q <= '0;
            else if (exmem_en)
                mem_q <= ex_q;

            if (memwb_en) begin
                wb_rd <= mem_q.rd;
                wb_wr <= mem_q.wr;
            end

            state_q <= state_d;

            if (!pc_en && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Forwarding producer info straight from registered state.
    assign rd_mem   = mem_q.rd;
    assign wr_mem   = mem_q.wr & (mem_q.rd != '0);
    assign wm_mem   = mem_q.memwr;
    assign mem_rt   = mem_q.rt;
    assign rd_wb    = wb_rd;
    assign wr_wb    = wb_wr & (wb_rd != '0);
    assign hz_state = state_q;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It keeps a shadow copy of each in-flight instruction's destination and memory-access information across ID/EX, EX/MEM and MEM/WB. From those copies it drives the producer side of the forwarding interface (`rd_mem`, `rd_wb`, `wr_mem`, `wr_wb`, `wm_mem`, `mem_rt`). It also generates every pipeline-register enable and flush, covering load-use stalls, instruction- and data-memory waits, and taken-branch/jump redirects, and keeps a stall-cycle counter.

## Interface
- No parameters. Register indices are `regbits_t` (5 bits) from `cpu_types_pkg`.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `CLK` input 1: clock; all state updates on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `ihit` input 1: instruction memory returned the fetch this cycle.
- `dhit` input 1: data memory completed the MEM-stage access this cycle.
- `dec_rs`, `dec_rt` input 5: source registers of the instruction in ID.
- `dec_uses_rt` input 1: the ID instruction reads `rt` as a source.
- `dec_rd` input 5: resolved destination of the ID instruction (`rd`, `rt` or 31).
- `dec_regwr`, `dec_memrd`, `dec_memwr` input 1: control bits of the ID instruction.
- `ex_redirect` input 1: the EX instruction is a taken branch or a jump.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` output 1: pipeline register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` output 1: synchronous clear to a bubble; a flush overrides the same register's enable.
- `rd_mem`, `rd_wb` output 5: destination register in MEM and in WB.
- `wr_mem`, `wr_wb` output 1: MEM / WB instruction writes a register, qualified by destination ≠ 0.
- `wm_mem` output 1: MEM instruction is a store.
- `mem_rt` output 5: `rt` field of the MEM instruction.
- `hz_state` output 2: registered hazard state, encoded RUN=0, LDSTALL=1, MEMWAIT=2, REDIRECT=3.
- `stall_cnt` output 16: saturating count of cycles in which `pc_en`=0.

## Operation
- **Shadow stages.**
  - `ex_{rd,rt,wr,memrd,memwr}` load the `dec_*` values when `idex_en`=1 and are cleared when `idex_flush`=1.
  - `mem_*` load `ex_*` under `exmem_en` and are cleared under `exmem_flush`.
  - `wb_{rd,wr}` load `mem_*` under `memwb_en`.
- **Hazard terms.**
  - `mem_busy` = (`mem_memrd` | `mem_memwr`) & !`dhit`.
  - `load_use` = `ex_memrd` & `ex_wr` & (`ex_rd`≠0) & (`ex_rd`==`dec_rs` | (`dec_uses_rt` & `ex_rd`==`dec_rt`)).
- **Priority (combinational, highest first).**
  1. `RST`: all enables 0, all flushes 1.
  2. `mem_busy` (MEMWAIT): all enables 0, no flushes. Every stage holds, including a pending redirect.
  3. `ex_redirect` (REDIRECT): `pc_en`=1, `ifid_flush`=1, `idex_flush`=1, `exmem_en`=1, `memwb_en`=1. The redirect is taken even when `ihit`=0.
  4. `load_use` (LDSTALL): `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `exmem_en`=1, `memwb_en`=1.
  5. `!ihit` (fetch wait, state RUN): `pc_en`=0, `ifid_flush`=1, `idex_en`=1, `exmem_en`=1, `memwb_en`=1.
  6. Normal (RUN): all enables 1, all flushes 0.
- `exmem_flush` is 1 only during reset.
- **Forwarding outputs** are direct from registered state:
  - `rd_mem`=`mem_rd`; `wr_mem`=`mem_wr`&(`mem_rd`≠0); `wm_mem`=`mem_memwr`; `mem_rt`=`mem_rt`.
  - `rd_wb`=`wb_rd`; `wr_wb`=`wb_wr`&(`wb_rd`≠0).
- **State register.** `hz_state` registers the case selected this cycle (fetch wait is reported as RUN).
- **Counter.** `stall_cnt` increments when `pc_en`=0 and `RST`=0, and saturates at 16'hFFFF.

## Timing
- Enables and flushes are combinational from the current inputs and state: zero latency, same cycle.
- Forwarding outputs and `hz_state` change only on `CLK` edges: one cycle after the causing condition.
- Reset values: all shadow fields 0, `rd_*`/`wr_*`/`wm_mem`/`mem_rt` = 0, `hz_state`=RUN, `stall_cnt`=0. Reset asserted mid-stall discards all state in that edge.
- A load-use stall lasts exactly 1 cycle when `dhit` is immediate: the bubble removes the dependency. If the load then waits in MEM, MEMWAIT holds the bubble in EX.
- MEMWAIT lasts until the first cycle with `dhit`=1. That cycle evaluates the lower-priority rules normally.
- Simultaneous `ex_redirect` and `load_use`: REDIRECT wins. The dependent instruction is flushed, so no stall is needed.
- Destination `$0` never asserts `wr_*` and never triggers `load_use`.

## Test plan
- **Reset:** hold `RST`=1 for 2 cycles with random inputs → all forwarding outputs 0, `hz_state`=0, `stall_cnt`=0, flushes 1, enables 0.
- **Load-use:**
  - Stimulus: `lw $5` (`dec_rd`=5, `dec_memrd`=1, `dec_regwr`=1) enters EX; ID holds `add` with `dec_rs`=5; `ihit`=`dhit`=1.
  - Required response: one cycle with `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `stall_cnt`=1.
  - Then `rd_mem`=5, `wr_mem`=1 for one cycle and `rd_wb`=5, `wr_wb`=1 the next.
- **Data-memory wait:** store in MEM (`mem_rt`=7) with `dhit`=0 for 3 cycles → all enables 0, `hz_state`=MEMWAIT, `wm_mem`=1 and `mem_rt`=7 held; `stall_cnt` advances by 3.
- **Redirect with load-use:**
  - Stimulus: `ex_redirect`=1 together with a `load_use` condition.
  - Required response: `ifid_flush`=`idex_flush`=1 and `pc_en`=1; next cycle `hz_state`=REDIRECT and `ex_*` cleared.
- **Fetch wait:** `ihit`=0 for 2 cycles with no other hazard → `pc_en`=0, `ifid_flush`=1, downstream stages advance, and `rd_wb` reflects the drained instruction.
- **`$0` and saturation:**
  - A load to `$0` followed by a dependent use → no stall, `wr_mem`=0.
  - Force `stall_cnt` to FFFE and stall 3 cycles → FFFF, held.
